// File: rtl/rv_decode_stage.sv
// -----------------------------------------------------------------------------
// rv_decode_stage
//   Pipelined RV32I instruction decoder sitting between instruction fetch and
//   register read / execute. Each accepted instruction word is decoded once,
//   on entry to a 2-entry skid buffer (head + skid), and the decoded bundle is
//   presented from the head entry one cycle after acceptance.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             drop every buffered bundle (branch redirect)
//   in_valid/in_ready/in_instr        upstream handshake and raw word
//   out_valid/out_ready               downstream handshake
//   out_rd/out_rs1/out_rs2            register indices
//   out_funct3                        raw funct3 field
//   out_alu_op                        0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,
//                                     7 SRA,8 SLT,9 SLTU,10 PASSB
//   out_imm/out_use_imm               sign-extended immediate, operand-B select
//   out_class                         0 R,1 OPIMM,2 LOAD,3 STORE,4 BRANCH,
//                                     5 JAL,6 JALR,7 LUI
//   out_illegal                       unknown opcode / bad funct3-funct7 combo
//   decode_count                      bundles handed off, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module rv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [3:0]       out_alu_op,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_use_imm,
    output logic [2:0]       out_class,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decode_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_OPIMM  = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;
    localparam logic [2:0] CLS_JALR   = 3'd6;
    localparam logic [2:0] CLS_LUI    = 3'd7;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [2:0]      cls;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Full RV32I field decode of one word. Any illegal combination collapses
    // the bundle to all-zero with only the illegal flag set.
    function automatic bundle_t decode_instr(input logic [31:0] instr);
        bundle_t    b;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        opcode = instr[6:0];
        f3     = instr[14:12];
        f7     = instr[31:25];
        b      = '0;
        bad    = 1'b0;
        case (opcode)
            OPC_OP: begin
                b.rd     = instr[11:7];
                b.rs1    = instr[19:15];
                b.rs2    = instr[24:20];
                b.funct3 = f3;
                b.cls    = CLS_R;
                case (f3)
                    3'b000:  b.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  b.alu_op = ALU_SLL;
                    3'b010:  b.alu_op = ALU_SLT;
                    3'b011:  b.alu_op = ALU_SLTU;
                    3'b100:  b.alu_op = ALU_XOR;
                    3'b101:  b.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  b.alu_op = ALU_OR;
                    default: b.alu_op = ALU_AND;
                endcase
                // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
                bad = !((f7 == F7_ZERO) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_OPIMM: begin
                b.rd      = instr[11:7];
                b.rs1     = instr[19:15];
                b.funct3  = f3;
                b.use_imm = 1'b1;
                b.cls     = CLS_OPIMM;
                b.imm     = {{20{instr[31]}}, instr[31:20]};
                case (f3)
                    3'b000: b.alu_op = ALU_ADD;
                    3'b001: begin
                        b.alu_op = ALU_SLL;
                        b.imm    = {27'd0, instr[24:20]};
                        bad      = (f7 != F7_ZERO);
                    end
                    3'b010: b.alu_op = ALU_SLT;
                    3'b011: b.alu_op = ALU_SLTU;
                    3'b100: b.alu_op = ALU_XOR;
                    3'b101: begin
                        b.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
                        b.imm    = {27'd0, instr[24:20]};
                        bad      = (f7 != F7_ZERO) && (f7 != F7_ALT);
                    end
                    3'b110:  b.alu_op = ALU_OR;
                    default: b.alu_op = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                b.rd      = instr[11:7];
                b.rs1     = instr[19:15];
                b.funct3  = f3;
                b.alu_op  = ALU_ADD;
                b.imm     = {{20{instr[31]}}, instr[31:20]};
                b.use_imm = 1'b1;
                b.cls     = CLS_LOAD;
                bad       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                b.rs1     = instr[19:15];
                b.rs2     = instr[24:20];
                b.funct3  = f3;
                b.alu_op  = ALU_ADD;
                b.imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                b.use_imm = 1'b1;
                b.cls     = CLS_STORE;
                bad       = (f3[2] == 1'b1) || (f3 == 3'b011);
            end
            OPC_BRANCH: begin
                b.rs1    = instr[19:15];
                b.rs2    = instr[24:20];
                b.funct3 = f3;
                b.alu_op = ALU_SUB;
                b.imm    = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
                b.cls    = CLS_BRANCH;
                bad      = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                b.rd      = instr[11:7];
                b.funct3  = f3;
                b.alu_op  = ALU_ADD;
                b.imm     = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
                b.use_imm = 1'b1;
                b.cls     = CLS_JAL;
            end
            OPC_JALR: begin
                b.rd      = instr[11:7];
                b.rs1     = instr[19:15];
                b.funct3  = f3;
                b.alu_op  = ALU_ADD;
                b.imm     = {{20{instr[31]}}, instr[31:20]};
                b.use_imm = 1'b1;
                b.cls     = CLS_JALR;
                bad       = (f3 != 3'b000);
            end
            OPC_LUI: begin
                b.rd      = instr[11:7];
                b.funct3  = f3;
                b.alu_op  = ALU_PASSB;
                b.imm     = {instr[31:12], 12'd0};
                b.use_imm = 1'b1;
                b.cls     = CLS_LUI;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            b         = '0;
            b.illegal = 1'b1;
        end else begin
            b.illegal = 1'b0;
        end
        return b;
    endfunction

    state_t           state_r, state_s;
    bundle_t          head_r, head_s;
    bundle_t          skid_r, skid_s;
    bundle_t          dec_s;
    logic             in_ready_r, in_ready_s;
    logic             out_valid_r, out_valid_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             accept_s;
    logic             consume_s;

    assign dec_s     = decode_instr(in_instr);
    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

    // Next-state logic for the head/skid buffer, handshake flags and counter.
    always_comb begin
        state_s = state_r;
        head_s  = head_r;
        skid_s  = skid_r;
        count_s = count_r;
        if (consume_s) begin
            count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_s = count_r;
        end
        if (flush) begin
            state_s = S_EMPTY;
            head_s  = '0;
            skid_s  = '0;
        end else begin
            case (state_r)
                S_EMPTY: begin
                    if (accept_s) begin
                        head_s  = dec_s;
                        state_s = S_ONE;
                    end else begin
                        state_s = S_EMPTY;
                    end
                end
                S_ONE: begin
                    case ({accept_s, consume_s})
                        2'b11: head_s = dec_s;
                        2'b10: begin
                            skid_s  = dec_s;
                            state_s = S_TWO;
                        end
                        2'b01: begin
                            head_s  = '0;
                            state_s = S_EMPTY;
                        end
                        default: state_s = S_ONE;
                    endcase
                end
                S_TWO: begin
                    // in_ready is low here, so only a consume can move things.
                    if (consume_s) begin
                        head_s  = skid_r;
                        skid_s  = '0;
                        state_s = S_ONE;
                    end else begin
                        state_s = S_TWO;
                    end
                end
                default: begin
                    state_s = S_EMPTY;
                    head_s  = '0;
                    skid_s  = '0;
                end
            endcase
        end
        in_ready_s  = (state_s != S_TWO);
        out_valid_s = (state_s != S_EMPTY);
    end

    // Buffer, flag and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_EMPTY;
            head_r      <= '0;
            skid_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            count_r     <= '0;
        end else begin
            state_r     <= state_s;
            head_r      <= head_s;
            skid_r      <= skid_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            count_r     <= count_s;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_rd       = head_r.rd;
    assign out_rs1      = head_r.rs1;
    assign out_rs2      = head_r.rs2;
    assign out_funct3   = head_r.funct3;
    assign out_alu_op   = head_r.alu_op;
    assign out_imm      = head_r.imm;
    assign out_use_imm  = head_r.use_imm;
    assign out_class    = head_r.cls;
    assign out_illegal  = head_r.illegal;
    assign decode_count = count_r;

endmodule

// File: tb/tb_rv_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_rv_decode_stage
//   Directed self-checking bench for rv_decode_stage. Inputs change 1 ns after
//   the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [3:0]  out_alu_op;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic [2:0]  out_class;
    logic        out_illegal;
    logic [31:0] decode_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_alu_op(out_alu_op), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_class(out_class),
        .out_illegal(out_illegal), .decode_count(decode_count)
    );

    // Bundle layout: rd rs1 rs2 funct3 alu_op imm use_imm class illegal
    wire [58:0] got = {out_rd, out_rs1, out_rs2, out_funct3, out_alu_op,
                       out_imm, out_use_imm, out_class, out_illegal};

    function automatic logic [58:0] bnd(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [3:0] alu, input logic [31:0] imm,
                                        input logic u, input logic [2:0] c,
                                        input logic ill);
        return {rd, rs1, rs2, f3, alu, imm, u, c, ill};
    endfunction

    function automatic logic [31:0] addi_word(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h0000_0013;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        step();
        in_valid = 1'b0;
        in_instr = 32'h0;
    endtask

    task automatic test_reset();
        tests++;
        if ({out_valid, in_ready, decode_count} !== {1'b0, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL reset_flags got valid=%b ready=%b cnt=%0d want 0 1 0",
                     out_valid, in_ready, decode_count);
        end
        tests++;
        if (got !== 59'd0) begin
            fails++;
            $display("FAIL reset_fields got %h want 0", got);
        end
    endtask

    task automatic test_rtype();
        logic [58:0] exp_b;
        out_ready = 1'b1;
        present(32'h002081B3);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL add_latency got valid=%b want 1", out_valid);
        end
        exp_b = bnd(5'd3, 5'd1, 5'd2, 3'd0, 4'd0, 32'h0, 1'b0, 3'd0, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL add got %h want %h", got, exp_b);
        end
        present(32'h402081B3);
        exp_b = bnd(5'd3, 5'd1, 5'd2, 3'd0, 4'd1, 32'h0, 1'b0, 3'd0, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL sub got %h want %h", got, exp_b);
        end
        present(32'h4020D1B3);
        exp_b = bnd(5'd3, 5'd1, 5'd2, 3'd5, 4'd7, 32'h0, 1'b0, 3'd0, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL sra got %h want %h", got, exp_b);
        end
        present(32'h0020B1B3);
        exp_b = bnd(5'd3, 5'd1, 5'd2, 3'd3, 4'd9, 32'h0, 1'b0, 3'd0, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL sltu got %h want %h", got, exp_b);
        end
        step();
    endtask

    task automatic test_opimm();
        logic [58:0] exp_b;
        out_ready = 1'b1;
        present(32'hFFF00293);
        exp_b = bnd(5'd5, 5'd0, 5'd0, 3'd0, 4'd0, 32'hFFFFFFFF, 1'b1, 3'd1, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL addi got %h want %h", got, exp_b);
        end
        present(32'h40315093);
        exp_b = bnd(5'd1, 5'd2, 5'd0, 3'd5, 4'd7, 32'h3, 1'b1, 3'd1, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL srai got %h want %h", got, exp_b);
        end
        present(32'h00311093);
        exp_b = bnd(5'd1, 5'd2, 5'd0, 3'd1, 4'd5, 32'h3, 1'b1, 3'd1, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL slli got %h want %h", got, exp_b);
        end
        step();
    endtask

    task automatic test_formats();
        logic [58:0] exp_b;
        out_ready = 1'b1;
        present(32'hFE208EE3);
        exp_b = bnd(5'd0, 5'd1, 5'd2, 3'd0, 4'd1, 32'hFFFFFFFC, 1'b0, 3'd4, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL beq got %h want %h", got, exp_b);
        end
        present(32'h0020A423);
        exp_b = bnd(5'd0, 5'd1, 5'd2, 3'd2, 4'd0, 32'h8, 1'b1, 3'd3, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL sw got %h want %h", got, exp_b);
        end
        present(32'h008000EF);
        exp_b = bnd(5'd1, 5'd0, 5'd0, 3'd0, 4'd0, 32'h8, 1'b1, 3'd5, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL jal got %h want %h", got, exp_b);
        end
        present(32'h12340237);
        exp_b = bnd(5'd4, 5'd0, 5'd0, 3'd0, 4'd10, 32'h12340000, 1'b1, 3'd7, 1'b0);
        tests++;
        if (got !== exp_b) begin
            fails++;
            $display("FAIL lui got %h want %h", got, exp_b);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] words [4];
        logic [58:0] exp_b;
        words[0] = 32'h00000000;
        words[1] = 32'h4020F1B3;
        words[2] = 32'h40311093;
        words[3] = 32'h0000B083;
        exp_b = bnd(5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 32'h0, 1'b0, 3'd0, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(words[i]);
            tests++;
            if ({out_valid, got} !== {1'b1, exp_b}) begin
                fails++;
                $display("FAIL illegal_%0d got v=%b %h want v=1 %h",
                         i, out_valid, got, exp_b);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   rcvd = 0;
        int   cyc  = 0;
        bit   saw_full = 1'b0;
        logic acc;
        logic con;
        logic [4:0] rd_seen;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        while ((rcvd < 6) && (cyc < 60)) begin
            in_valid  = (sent < 6);
            in_instr  = addi_word(sent + 1);
            out_ready = (cyc >= 3);
            #1;
            acc     = in_valid && in_ready;
            con     = out_valid && out_ready;
            rd_seen = out_rd;
            @(posedge clk);
            #1;
            if (acc) sent++;
            if (con) begin
                tests++;
                if (rd_seen !== 5'(rcvd + 1)) begin
                    fails++;
                    $display("FAIL order_%0d got rd=%0d want %0d", rcvd, rd_seen, rcvd + 1);
                end
                rcvd++;
            end
            if (!in_ready) saw_full = 1'b1;
            cyc++;
        end
        in_valid = 1'b0;
        tests++;
        if (rcvd !== 6) begin
            fails++;
            $display("FAIL stream_count got %0d want 6", rcvd);
        end
        tests++;
        if (saw_full !== 1'b1) begin
            fails++;
            $display("FAIL in_ready_drop got %b want 1", saw_full);
        end
        tests++;
        if ({out_valid, in_ready, decode_count} !== {1'b0, 1'b1, 32'd6}) begin
            fails++;
            $display("FAIL stream_end got v=%b r=%b cnt=%0d want 0 1 6",
                     out_valid, in_ready, decode_count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_instr = addi_word(k + 10);
            step();
            tests++;
            if ({out_valid, in_ready, out_rd} !== {1'b1, 1'b1, 5'(k + 10)}) begin
                fails++;
                $display("FAIL b2b_%0d got v=%b r=%b rd=%0d want 1 1 %0d",
                         k, out_valid, in_ready, out_rd, k + 10);
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if ({out_valid, decode_count} !== {1'b0, 32'd9}) begin
            fails++;
            $display("FAIL b2b_end got v=%b cnt=%0d want 0 9", out_valid, decode_count);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        out_ready = 1'b0;
        present(addi_word(20));
        present(addi_word(21));
        tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            fails++;
            $display("FAIL full_before_flush got v=%b r=%b want 1 0", out_valid, in_ready);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = addi_word(22);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if ({out_valid, in_ready, decode_count} !== {1'b0, 1'b1, 32'd9}) begin
            fails++;
            $display("FAIL flush got v=%b r=%b cnt=%0d want 0 1 9",
                     out_valid, in_ready, decode_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL flush_leak got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        present(addi_word(7));
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({out_valid, in_ready, decode_count, got} !== {1'b0, 1'b1, 32'd0, 59'd0}) begin
            fails++;
            $display("FAIL reset_mid got v=%b r=%b cnt=%0d f=%h want 0 1 0 0",
                     out_valid, in_ready, decode_count, got);
        end
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        tests++;
        if ({out_valid, decode_count} !== {1'b0, 32'd0}) begin
            fails++;
            $display("FAIL reset_no_emit got v=%b cnt=%0d want 0 0", out_valid, decode_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        test_reset();
        test_rtype();
        test_opimm();
        test_formats();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
